// File: rtl/mix_pkg.sv
// rtl/mix_pkg.sv - shared types and constants for the wet/dry mix controller
package mix_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL_DRY,
        MUL_WET,
        ROUND
    } mix_state_e;

    // Unity coefficient (alpha = 1.0) for a given number of fraction bits.
    function automatic int unsigned coef_one(input int unsigned coef_w);
        return 32'd1 << coef_w;
    endfunction

    // Half an LSB of the output, added before the final arithmetic shift.
    function automatic int unsigned round_const(input int unsigned coef_w);
        return 32'd1 << (coef_w - 1);
    endfunction

endpackage

// File: rtl/mix_coef_ramp.sv
// rtl/mix_coef_ramp.sv - mix coefficient target register and zipper-free ramp
module mix_coef_ramp
    import mix_pkg::*;
#(
    parameter int COEF_W    = 8,
    parameter int RAMP_STEP = 1,
    parameter int MIX_INIT  = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [COEF_W:0]   target_i,
    input  logic              target_valid_i,
    input  logic              step_en_i,
    output logic [COEF_W:0]   current_o,
    output logic              busy_o
);

    localparam logic [COEF_W:0] ONE  = (COEF_W + 1)'(coef_one(COEF_W));
    localparam logic [COEF_W:0] STEP = (COEF_W + 1)'(RAMP_STEP);
    localparam logic [COEF_W:0] INIT = (COEF_W + 1)'(MIX_INIT);

    logic [COEF_W:0] target_q, target_d;
    logic [COEF_W:0] current_q, current_d;
    logic [COEF_W:0] diff, delta;
    logic            busy_q;

    always_comb begin
        target_d = target_q;
        if (target_valid_i) begin
            target_d = (target_i > ONE) ? ONE : target_i;
        end
        diff  = (target_q >= current_q) ? (target_q - current_q) : (current_q - target_q);
        delta = (diff > STEP) ? STEP : diff;
        // The step uses the pre-load target, so a load on a step edge lands next step.
        current_d = current_q;
        if (step_en_i) begin
            current_d = (target_q >= current_q) ? (current_q + delta) : (current_q - delta);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            target_q  <= INIT;
            current_q <= INIT;
            busy_q    <= 1'b0;
        end else begin
            target_q  <= target_d;
            current_q <= current_d;
            busy_q    <= (current_d != target_d);
        end
    end

    assign current_o = current_q;
    assign busy_o    = busy_q;

endmodule

// File: rtl/mix_ctrl.sv
// rtl/mix_ctrl.sv - wet/dry mix sequencer, shared MAC; MIX_OVERRUN_CNT_EN adds overrunCnt_o
module mix_ctrl
    import mix_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int COEF_W    = 8,
    parameter int RAMP_STEP = 1,
    parameter int MIX_INIT  = 128
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic signed [WIDTH-1:0] pktDry_i,
    input  logic                    pktDryChanged_i,
    input  logic signed [WIDTH-1:0] pktWet_i,
    input  logic                    pktWetChanged_i,
    input  logic [COEF_W:0]         mixTarget_i,
    input  logic                    mixTargetValid_i,
    output logic signed [WIDTH-1:0] pktMixed_o,
    output logic                    pktMixedChanged_o,
    output logic [COEF_W:0]         mixCurrent_o,
    output logic                    rampBusy_o,
    output logic                    overrun_o
`ifdef MIX_OVERRUN_CNT_EN
    ,
    output logic [15:0]             overrunCnt_o
`endif
);

    localparam int AW = WIDTH + COEF_W + 1;
    localparam logic [COEF_W:0]     ONE = (COEF_W + 1)'(coef_one(COEF_W));
    localparam logic signed [AW-1:0] RND = AW'(round_const(COEF_W));

    mix_state_e              state_q;
    logic signed [WIDTH-1:0] dry_hold_q, dry_hold_d, wet_hold_q, wet_hold_d;
    logic                    dry_flag_q, dry_flag_d, wet_flag_q, wet_flag_d;
    logic signed [WIDTH-1:0] dry_w_q, wet_w_q;
    logic [COEF_W:0]         alpha_w_q;
    logic signed [AW-1:0]    acc_q;
    logic signed [WIDTH-1:0] mixed_q;
    logic                    mixed_chg_q;
    logic                    overrun_q, overrun_d;
    logic                    consume;
    logic signed [AW-1:0]    mul_a, mul_b, prod;

    assign consume = (state_q == IDLE) && dry_flag_q && wet_flag_q;

    // A strobe on the consume edge re-arms its flag and is not an overrun.
    always_comb begin
        dry_hold_d = pktDryChanged_i ? pktDry_i : dry_hold_q;
        wet_hold_d = pktWetChanged_i ? pktWet_i : wet_hold_q;
        dry_flag_d = (dry_flag_q && !consume) || pktDryChanged_i;
        wet_flag_d = (wet_flag_q && !consume) || pktWetChanged_i;
        overrun_d  = (pktDryChanged_i && dry_flag_q && !consume)
                  || (pktWetChanged_i && wet_flag_q && !consume);
    end

    // One multiplier serves both products; the coefficient is always non-negative.
    always_comb begin
        mul_a = AW'((state_q == MUL_WET) ? wet_w_q : dry_w_q);
        mul_b = AW'({1'b0, (state_q == MUL_WET) ? alpha_w_q : (ONE - alpha_w_q)});
        prod  = mul_a * mul_b;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            dry_hold_q  <= '0;
            wet_hold_q  <= '0;
            dry_flag_q  <= 1'b0;
            wet_flag_q  <= 1'b0;
            dry_w_q     <= '0;
            wet_w_q     <= '0;
            alpha_w_q   <= '0;
            acc_q       <= '0;
            mixed_q     <= '0;
            mixed_chg_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            dry_hold_q  <= dry_hold_d;
            wet_hold_q  <= wet_hold_d;
            dry_flag_q  <= dry_flag_d;
            wet_flag_q  <= wet_flag_d;
            overrun_q   <= overrun_d;
            mixed_chg_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (consume) begin
                        dry_w_q   <= dry_hold_q;
                        wet_w_q   <= wet_hold_q;
                        alpha_w_q <= mixCurrent_o;
                        state_q   <= MUL_DRY;
                    end
                end
                MUL_DRY: begin
                    acc_q   <= prod;
                    state_q <= MUL_WET;
                end
                MUL_WET: begin
                    acc_q   <= acc_q + prod;
                    state_q <= ROUND;
                end
                ROUND: begin
                    mixed_q     <= WIDTH'((acc_q + RND) >>> COEF_W);
                    mixed_chg_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mix_coef_ramp #(
        .COEF_W    (COEF_W),
        .RAMP_STEP (RAMP_STEP),
        .MIX_INIT  (MIX_INIT)
    ) u_ramp (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .target_i       (mixTarget_i),
        .target_valid_i (mixTargetValid_i),
        .step_en_i      (state_q == ROUND),
        .current_o      (mixCurrent_o),
        .busy_o         (rampBusy_o)
    );

    assign pktMixed_o        = mixed_q;
    assign pktMixedChanged_o = mixed_chg_q;
    assign overrun_o         = overrun_q;

`ifdef MIX_OVERRUN_CNT_EN
    logic [15:0] ovr_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovr_cnt_q <= '0;
        end else if (overrun_d && (ovr_cnt_q != 16'hFFFF)) begin
            ovr_cnt_q <= ovr_cnt_q + 16'd1;
        end
    end

    assign overrunCnt_o = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_mix_ctrl.sv
// tb/tb_mix_ctrl.sv - self-checking bench for mix_ctrl against a sample-level reference model
module tb_mix_ctrl;

    localparam int WIDTH     = 16;
    localparam int COEF_W    = 8;
    localparam int RAMP_STEP = 1;
    localparam int MIX_INIT  = 128;
    localparam int ONE       = 1 << COEF_W;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic signed [WIDTH-1:0] dry = '0;
    logic signed [WIDTH-1:0] wet = '0;
    logic                    dry_v = 1'b0;
    logic                    wet_v = 1'b0;
    logic [COEF_W:0]         tgt = '0;
    logic                    tgt_v = 1'b0;
    logic signed [WIDTH-1:0] mixed;
    logic                    mixed_chg;
    logic [COEF_W:0]         cur;
    logic                    busy;
    logic                    ovr;
`ifdef MIX_OVERRUN_CNT_EN
    logic [15:0]             ocnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state: one held sample per channel, pending result, alpha current/target.
    int m_hd, m_hw, m_cnt, m_val, m_out, m_cur, m_tgt, m_ocnt;
    bit m_fd, m_fw, m_chg, m_ovr;

    int n_out, n_ovr;

    mix_ctrl #(
        .WIDTH     (WIDTH),
        .COEF_W    (COEF_W),
        .RAMP_STEP (RAMP_STEP),
        .MIX_INIT  (MIX_INIT)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .pktDry_i          (dry),
        .pktDryChanged_i   (dry_v),
        .pktWet_i          (wet),
        .pktWetChanged_i   (wet_v),
        .mixTarget_i       (tgt),
        .mixTargetValid_i  (tgt_v),
        .pktMixed_o        (mixed),
        .pktMixedChanged_o (mixed_chg),
        .mixCurrent_o      (cur),
        .rampBusy_o        (busy),
        .overrun_o         (ovr)
`ifdef MIX_OVERRUN_CNT_EN
        ,
        .overrunCnt_o      (ocnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic int mix_ref(int d, int w, int a);
        longint s;
        s = longint'(d) * longint'(ONE - a) + longint'(w) * longint'(a) + longint'(ONE / 2);
        return int'(s >>> COEF_W);
    endfunction

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hd = 0; m_hw = 0; m_fd = 0; m_fw = 0;
        m_cnt = 0; m_val = 0; m_out = 0;
        m_cur = MIX_INIT; m_tgt = MIX_INIT;
        m_ocnt = 0; m_chg = 0; m_ovr = 0;
    endtask

    // Advance the model over the coming edge, clock the DUT, then compare.
    task automatic step();
        m_chg = 0;
        m_ovr = 0;
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_out = m_val;
                m_chg = 1;
                if (m_cur < m_tgt)
                    m_cur += (m_tgt - m_cur > RAMP_STEP) ? RAMP_STEP : (m_tgt - m_cur);
                else if (m_cur > m_tgt)
                    m_cur -= (m_cur - m_tgt > RAMP_STEP) ? RAMP_STEP : (m_cur - m_tgt);
            end
        end else if (m_fd && m_fw) begin
            m_val = mix_ref(m_hd, m_hw, m_cur);
            m_cnt = 3;
            m_fd  = 0;
            m_fw  = 0;
        end
        if (dry_v) begin
            if (m_fd) m_ovr = 1;
            m_hd = int'(dry);
            m_fd = 1;
        end
        if (wet_v) begin
            if (m_fw) m_ovr = 1;
            m_hw = int'(wet);
            m_fw = 1;
        end
        if (tgt_v) m_tgt = (int'(tgt) > ONE) ? ONE : int'(tgt);
        if (m_ovr && m_ocnt < 65535) m_ocnt++;

        @(posedge clk);
        #1;
        dry_v = 1'b0;
        wet_v = 1'b0;
        tgt_v = 1'b0;
        if (mixed_chg) n_out++;
        if (ovr) n_ovr++;

        chk("strobe", int'(mixed_chg), int'(m_chg));
        chk("mixed", int'(mixed), m_out);
        chk("overrun", int'(ovr), int'(m_ovr));
        chk("alpha_cur", int'(cur), m_cur);
        chk("ramp_busy", int'(busy), int'(m_cur != m_tgt));
`ifdef MIX_OVERRUN_CNT_EN
        chk("overrun_cnt", int'(ocnt), m_ocnt);
`endif
    endtask

    task automatic wait_out();
        bit got;
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            step();
            got = mixed_chg;
        end
        chk("output_seen", int'(got), 1);
    endtask

    task automatic send_pair(int d, int w, int gap, bit wet_first);
        if (gap == 0) begin
            dry = WIDTH'(d); wet = WIDTH'(w); dry_v = 1'b1; wet_v = 1'b1;
            step();
        end else begin
            if (wet_first) begin wet = WIDTH'(w); wet_v = 1'b1; end
            else           begin dry = WIDTH'(d); dry_v = 1'b1; end
            step();
            repeat (gap - 1) step();
            if (wet_first) begin dry = WIDTH'(d); dry_v = 1'b1; end
            else           begin wet = WIDTH'(w); wet_v = 1'b1; end
            step();
        end
        wait_out();
    endtask

    task automatic rand_pair();
        send_pair(int'($signed(16'($urandom))), int'($signed(16'($urandom))),
                  int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    endtask

    initial begin
        model_reset();
        n_out = 0;
        n_ovr = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mixed", int'(mixed), 0);
        chk("rst_strobe", int'(mixed_chg), 0);
        chk("rst_overrun", int'(ovr), 0);
        chk("rst_alpha", int'(cur), MIX_INIT);
        chk("rst_busy", int'(busy), 0);
`ifdef MIX_OVERRUN_CNT_EN
        chk("rst_ocnt", int'(ocnt), 0);
`endif
        rst = 1'b0;

        // Latency: dry then wet, result 4 edges after wet capture
        dry = 16'sd1000; dry_v = 1'b1; step();
        wet = 16'sd3000; wet_v = 1'b1; step();
        repeat (3) step();
        chk("lat_pre_strobe", int'(mixed_chg), 0);
        step();
        chk("lat_strobe", int'(mixed_chg), 1);
        chk("lat_value", int'(mixed), 2000);
        chk("lat_alpha", int'(cur), 128);

        // Ramp 128 -> 132 one step per output
        tgt = 9'd132; tgt_v = 1'b1; step();
        for (int k = 1; k <= 4; k++) begin
            rand_pair();
            chk("ramp_alpha", int'(cur), 128 + k);
        end
        chk("ramp_done_busy", int'(busy), 0);

        // Overrun: second dry overwrites first
        n_ovr = 0;
        dry = 16'sd7; dry_v = 1'b1; step();
        dry = -16'sd55; dry_v = 1'b1; step();
        wet = 16'sd99; wet_v = 1'b1; step();
        wait_out();
        chk("ovr_pulses", n_ovr, 1);
        chk("ovr_value", int'(mixed), mix_ref(-55, 99, 132));
`ifdef MIX_OVERRUN_CNT_EN
        chk("ovr_cnt", int'(ocnt), 1);
`endif

        // Strobes on both channels every cycle for 20 cycles
        n_out = 0;
        n_ovr = 0;
        for (int i = 0; i < 20; i++) begin
            dry = WIDTH'($urandom); wet = WIDTH'($urandom);
            dry_v = 1'b1; wet_v = 1'b1;
            step();
        end
        repeat (10) step();
        chk("burst_outputs", n_out, 6);
        chk("burst_overruns", n_ovr, 14);

        // Ramp to alpha = 0: output equals dry
        tgt = 9'd0; tgt_v = 1'b1; step();
        repeat (140) rand_pair();
        chk("alpha_zero", int'(cur), 0);
        send_pair(-1234, 500, 1, 1'b0);
        chk("dry_only", int'(mixed), -1234);

        // Over-range target clamps to unity: output equals wet
        tgt = 9'd300; tgt_v = 1'b1; step();
        repeat (260) rand_pair();
        chk("alpha_clamp", int'(cur), ONE);
        send_pair(-1234, 500, 2, 1'b1);
        chk("wet_only", int'(mixed), 500);

        // Reset while the FSM is in MUL_WET
        dry = 16'sd11; wet = 16'sd22; dry_v = 1'b1; wet_v = 1'b1;
        step();
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_mixed", int'(mixed), 0);
        chk("midrst_strobe", int'(mixed_chg), 0);
        chk("midrst_alpha", int'(cur), MIX_INIT);
        chk("midrst_busy", int'(busy), 0);
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("midrst_hold_strobe", int'(mixed_chg), 0);
        end
        rst = 1'b0;
        send_pair(1000, 3000, 0, 1'b0);
        chk("post_rst_value", int'(mixed), 2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
